serial_add_ctrl: RTL and testbench

- Bit-serial sequencer for the team's one-bit full-adder cell (x, y, z -> s, c).
- Feeds N-bit operands through the single cell LSB-first, one bit per clock, keeping the carry in a flip-flop.
- Supports add and subtract, and assembles the N-bit result plus flags.
- Sits between the CPU control unit and the adder cell. Used as a low-area ALU add path.

---
 rtl/alu_pkg.sv | 13 +
 rtl/serial_add_ctrl_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: controller state encoding and add/sub opcode values.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell: s = x ^ y ^ z, c = majority(x, y, z).
module serial_add_ctrl_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: pushes N-bit operands LSB-first through one
// full-adder cell, keeping the carry in a flop, and assembles sum and flags.
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic          carry;
    logic          carry_msb;
    logic [CW-1:0] cnt;
    logic          fa_s;
    logic          fa_c;
    logic          load;
    logic          step;
    logic          last;

    serial_add_ctrl_fa u_fa (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus datapath strobes.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    last     = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nx == ST_RUN);
            done <= (state_nx == ST_DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= (sub == OP_SUB) ? ~b : b;
                carry <= (sub == OP_SUB) ? 1'b1 : cin;
                cnt   <= '0;
            end else if (step) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {fa_s, res_sr[N-1:1]};
                carry  <= fa_c;
                cnt    <= cnt + CW'(1);
                // Carry out of bit N-2 is the carry into the MSB.
                if (cnt == CW'(N - 2)) begin
                    carry_msb <= fa_c;
                end
                if (last) begin
                    sum  <= {fa_s, res_sr[N-1:1]};
                    cout <= fa_c;
                    ovf  <= carry_msb ^ fa_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic/timing model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_add_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    serial_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [N+1:0] ref_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                                            input logic op_sub, input logic op_cin);
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int r;
        logic rc;
        logic ro;
        ua = int'(op_a);
        ub = int'(op_b);
        sa = $signed(op_a);
        sb = $signed(op_b);
        if (op_sub) begin
            u  = ua - ub;
            r  = sa - sb;
            rc = (ua >= ub);
        end else begin
            u  = ua + ub + int'(op_cin);
            r  = sa + sb + int'(op_cin);
            rc = (u >= (1 << N));
        end
        ro = (r > (1 << (N - 1)) - 1) || (r < -(1 << (N - 1)));
        return {ro, rc, N'(u)};
    endfunction

    // Model: "since" counts edges after acceptance; -1 means idle and ready.
    int           since = -1;
    logic [N+1:0] pend;
    logic [N-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;

    always @(posedge clk) begin
        if (rst) begin
            since  = -1;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (since < 0) begin
            if (start) begin
                pend  = ref_op(a, b, sub, cin);
                since = 0;
            end
        end else begin
            since++;
            if (since == int'(N)) begin
                {m_ovf, m_cout, m_sum} = pend;
            end else if (since == int'(N) + 1) begin
                since = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(since >= 0 && since < int'(N)));
            check("done", 32'(done), 32'(since == int'(N)));
            check("sum",  32'(sum),  32'(m_sum));
            check("cout", 32'(cout), 32'(m_cout));
            check("ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    // One operation; checks latency and the literal expected results at done.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic ts,
                          input logic tc, input logic [N-1:0] es, input logic ec, input logic eo);
        int k;
        @(negedge clk);
        a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_; sub = ~ts; cin = ~tc;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'(1));
        check("latency", 32'(k), 32'(N + 1));
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_cout", 32'(cout), 32'(ec));
        check("lit_ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst = 1'b0;

        run_op(8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Abort mid-RUN with reset; extra start and operand changes must be ignored.
        @(negedge clk);
        a = 8'h35; b = 8'h0A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_cout", 32'(cout), 32'(0));
        check("abort_ovf", 32'(ovf), 32'(0));
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Held start: back-to-back operations every N+2 clocks.
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("held_first", 32'(done), 32'(1));
        check("held_sum0", 32'(sum), 32'(8'h30));
        for (int p = 0; p < 2; p++) begin
            k = 0;
            @(negedge clk);
            k++;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("held_interval", 32'(k), 32'(N + 2));
            check("held_sum", 32'(sum), 32'(8'h30));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
